// File: rtl/uart_rx_byte.sv
// UART 8N1 receive framer driven by an external mid-bit bit-rate generator.
// Detects the start edge, samples on bps_clk, and emits a valid or framing-error strobe.
module uart_rx_byte #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  input  logic       bps_clk,
  output logic       bps_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned SHAMT = 8 - DATA_BITS;
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [TMO_W-1:0] tmo;
  logic             fall;
  logic             tmo_hit;

  assign fall    = s3 & ~s2;
  assign tmo_hit = (state != IDLE) && !bps_clk && (tmo == TMO_MAX);

  // bps_start is high exactly while the FSM is out of IDLE.
  assign rx_busy = bps_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bps_start <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      tmo       <= '0;
    end else begin
      s1        <= rs232_rx;
      s2        <= s1;
      s3        <= s2;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Watchdog: restarts on every sample pulse, saturates otherwise.
      if (state == IDLE || bps_clk) begin
        tmo <= '0;
      end else if (tmo != TMO_MAX) begin
        tmo <= tmo + TMO_W'(1);
      end

      if (tmo_hit) begin
        state     <= IDLE;
        bps_start <= 1'b0;
        frame_err <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state     <= START;
              bps_start <= 1'b1;
            end
          end
          START: begin
            if (bps_clk) begin
              if (!s2) begin
                state   <= DATA;
                bit_cnt <= 3'd0;
              end else begin
                state     <= IDLE;
                bps_start <= 1'b0;
              end
            end
          end
          DATA: begin
            if (bps_clk) begin
              shift   <= {s2, shift[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                state <= STOP;
              end
            end
          end
          STOP: begin
            if (bps_clk) begin
              if (s2) begin
                rx_data  <= shift >> SHAMT;
                rx_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              state     <= IDLE;
              bps_start <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            bps_start <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
